// File: rtl/spike_fwd_dma_if.sv
// Wishbone master/slave bundle for the spike forwarding DMA.
//   wbm_cyc_o, wbm_stb_o, wbm_we_o : master controls
//   wbm_sel_o                      : byte selects
//   wbm_adr_o, wbm_dat_o           : address and write data
//   wbm_ack_i, wbm_dat_i           : acknowledge and read data from the responder
interface spike_fwd_dma_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/spike_fwd_dma.sv
// Forwards one timestep of output spikes from core 0 to core 1 over Wishbone.
// Each of NUM_WORDS words is read from SRC_BASE+4*idx, then written to
// DST_BASE+4*idx; the popcount of every word read is accumulated.
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   start_i            : single-cycle transfer request (honoured in IDLE only)
//   busy_o             : transfer in progress (RD/RGAP/WR/WGAP)
//   done_o             : one-cycle pulse at the end of a transfer or abort
//   err_o              : sticky ack timeout flag, cleared at next start
//   spike_count_o      : popcount over all words read in this transfer
//   wbm                : Wishbone master bundle
module spike_fwd_dma #(
  parameter logic [31:0] SRC_BASE  = 32'h8004_0000,
  parameter logic [31:0] DST_BASE  = 32'h8006_0000,
  parameter int          NUM_WORDS = 8,
  parameter int          TIMEOUT   = 16,
  parameter int          SKIP_ZERO = 0,
  parameter int          CNT_W     = 9
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] spike_count_o,
  spike_fwd_dma_if.master  wbm
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RGAP, S_WR, S_WGAP, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      buf_q, buf_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  logic is_rd, is_wr, is_last, tmo_hit;
  logic [31:0] off;

  assign is_rd   = (state_q == S_RD);
  assign is_wr   = (state_q == S_WR);
  assign is_last = (idx_q == IDX_LAST);
  assign tmo_hit = (tmo_q == TMO_LAST);
  assign off     = 32'(idx_q) << 2;

  // Bus outputs decode straight from registered state, so an asynchronous
  // reset drops CYC/STB in the same instant. Address/data/we are forced to
  // zero outside a strobe.
  assign wbm.wbm_cyc_o = is_rd | is_wr;
  assign wbm.wbm_stb_o = is_rd | is_wr;
  assign wbm.wbm_we_o  = is_wr;
  assign wbm.wbm_sel_o = (is_rd | is_wr) ? 4'hF : 4'h0;
  assign wbm.wbm_adr_o = is_rd ? (SRC_BASE + off) : is_wr ? (DST_BASE + off) : 32'h0;
  assign wbm.wbm_dat_o = is_wr ? buf_q : 32'h0;

  assign busy_o        = is_rd | is_wr | (state_q == S_RGAP) | (state_q == S_WGAP);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
  assign spike_count_o = cnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RD;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
        end
      end
      S_RD: begin
        if (wbm.wbm_ack_i) begin
          buf_d   = wbm.wbm_dat_i;
          cnt_d   = cnt_q + CNT_W'(popcnt32(wbm.wbm_dat_i));
          state_d = S_RGAP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      // Gap states ignore ack: responders may hold it while STB was high.
      S_RGAP: begin
        tmo_d = '0;
        if ((SKIP_ZERO != 0) && (buf_q == 32'h0)) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (wbm.wbm_ack_i) begin
          // DONE has STB low, so it serves as the gap after the final write.
          state_d = is_last ? S_DONE : S_WGAP;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WGAP: begin
        tmo_d = '0;
        if (is_last) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_spike_fwd_dma.sv
// Directed bench: two DUTs (SKIP_ZERO=0 and 1) each on its own memory model.
module tb_spike_fwd_dma;
  localparam logic [31:0] SRC = 32'h8004_0000;
  localparam logic [31:0] DST = 32'h8006_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       start_v = 2'b00;
  logic [1:0]       busy_v, done_v, err_v, cyc_v, stb_v, we_v, dup_v, bad_v;
  logic [1:0][8:0]  cnt_v;
  logic [1:0][3:0]  sel_v;
  logic [1:0][31:0] adr_v, dat_v;
  logic [1:0][7:0]  rd_n_v, wr_n_v, rd_mask_v, wr_mask_v, stb_mask_v, max_run_v;
  logic [1:0][7:0][31:0] dst_v;

  logic [31:0] src [8];
  logic        ack_mode = 1'b0;  // 0: one-cycle ack pulse, 1: ack held while STB high
  int          block_wr = -1;    // word index whose write is never acked
  logic        clr_log  = 1'b0;

  int pass_n = 0;
  int tot_n  = 0;

  genvar g;
  for (g = 0; g < 2; g++) begin : u
    spike_fwd_dma_if bus();
    logic [7:0] rd_n, wr_n, rd_mask, wr_mask, stb_mask, run, max_run;
    logic       dup, bad;
    logic [7:0][31:0] dst;
    wire  [2:0] wi  = bus.wbm_adr_o[4:2];
    wire        blk = bus.wbm_we_o && (block_wr == int'(wi));

    spike_fwd_dma #(.SKIP_ZERO(g)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_v[g]),
      .busy_o(busy_v[g]), .done_o(done_v[g]), .err_o(err_v[g]),
      .spike_count_o(cnt_v[g]), .wbm(bus.master)
    );

    assign bus.wbm_dat_i = src[wi];
    assign cyc_v[g] = bus.wbm_cyc_o;
    assign stb_v[g] = bus.wbm_stb_o;
    assign we_v[g]  = bus.wbm_we_o;
    assign sel_v[g] = bus.wbm_sel_o;
    assign adr_v[g] = bus.wbm_adr_o;
    assign dat_v[g] = bus.wbm_dat_o;
    assign rd_n_v[g] = rd_n;
    assign wr_n_v[g] = wr_n;
    assign rd_mask_v[g] = rd_mask;
    assign wr_mask_v[g] = wr_mask;
    assign stb_mask_v[g] = stb_mask;
    assign max_run_v[g] = max_run;
    assign dup_v[g] = dup;
    assign bad_v[g] = bad;
    assign dst_v[g] = dst;

    always @(posedge clk) begin
      if (rst) bus.wbm_ack_i <= 1'b0;
      else if (ack_mode) bus.wbm_ack_i <= bus.wbm_stb_o && !blk;
      else bus.wbm_ack_i <= bus.wbm_stb_o && !bus.wbm_ack_i && !blk;
      if (clr_log) begin
        rd_n <= '0; wr_n <= '0; rd_mask <= '0; wr_mask <= '0; stb_mask <= '0;
        run <= '0; max_run <= '0; dup <= 1'b0; bad <= 1'b0; dst <= '0;
      end else begin
        if (bus.wbm_stb_o) begin
          stb_mask[wi] <= 1'b1;
          run <= 8'(run + 1);
          if (8'(run + 1) > max_run) max_run <= 8'(run + 1);
          if (bus.wbm_adr_o[1:0] != 2'b00 ||
              (bus.wbm_we_o  && bus.wbm_adr_o[31:5] != DST[31:5]) ||
              (!bus.wbm_we_o && bus.wbm_adr_o[31:5] != SRC[31:5])) bad <= 1'b1;
        end else begin
          run <= '0;
        end
        if (bus.wbm_stb_o && bus.wbm_ack_i) begin
          if (bus.wbm_we_o) begin
            wr_n <= wr_n + 8'd1;
            wr_mask[wi] <= 1'b1;
            dst[wi] <= bus.wbm_dat_o;
          end else begin
            rd_n <= rd_n + 8'd1;
            if (rd_mask[wi]) dup <= 1'b1;
            rd_mask[wi] <= 1'b1;
          end
        end
      end
    end
  end

  // Cycle snapshots of DUT outputs, n = cycles after the start-sampling edge.
  logic        snap_stb [1:8];
  logic        snap_we  [1:8];
  logic        snap_busy[1:8];
  logic [3:0]  snap_sel [1:8];
  logic [31:0] snap_adr [1:8];
  logic [31:0] snap_dat [1:8];
  logic        snap_err1;
  logic [8:0]  snap_cnt1;

  task automatic clear_log();
    @(negedge clk); clr_log = 1'b1;
    @(negedge clk); clr_log = 1'b0;
  endtask

  task automatic load_src(input logic [31:0] w0, w1, w2, w3, w4);
    src[0] = w0; src[1] = w1; src[2] = w2; src[3] = w3; src[4] = w4;
    for (int i = 5; i < 8; i++) src[i] = 32'h0;
  endtask

  // Pulses start, then returns the cycle index of done_o (0 if never seen).
  task automatic run_xfer(input int which, input int pulse_at, output int lat);
    @(negedge clk); start_v[which] = 1'b1;
    @(negedge clk); start_v[which] = 1'b0;
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      if (n <= 8) begin
        snap_stb[n] = stb_v[which]; snap_we[n] = we_v[which];
        snap_busy[n] = busy_v[which]; snap_sel[n] = sel_v[which];
        snap_adr[n] = adr_v[which]; snap_dat[n] = dat_v[which];
      end
      if (n == 1) begin snap_err1 = err_v[which]; snap_cnt1 = cnt_v[which]; end
      start_v[which] = (n == pulse_at);
      if (done_v[which]) begin lat = n; break; end
      @(negedge clk);
    end
    start_v[which] = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tot_n++; if ({busy_v[0], done_v[0], err_v[0]} !== 3'b000) $display("FAIL rst_status got %b exp 000", {busy_v[0], done_v[0], err_v[0]}); else pass_n++;
    tot_n++; if (cnt_v[0] !== 9'd0) $display("FAIL rst_count got %0d exp 0", cnt_v[0]); else pass_n++;
    tot_n++; if ({cyc_v[0], stb_v[0], we_v[0], sel_v[0]} !== 7'd0) $display("FAIL rst_ctrl got %b exp 0", {cyc_v[0], stb_v[0], we_v[0], sel_v[0]}); else pass_n++;
    tot_n++; if ({adr_v[0], dat_v[0]} !== 64'd0) $display("FAIL rst_bus got %h exp 0", {adr_v[0], dat_v[0]}); else pass_n++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int lat;
    logic ok;
    load_src(32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    ack_mode = 1'b0; block_wr = -1;
    clear_log();
    run_xfer(0, 0, lat);
    tot_n++; if (lat !== 48) $display("FAIL norm_done_lat got %0d exp 48", lat); else pass_n++;
    tot_n++; if ({snap_busy[1], snap_stb[1], snap_we[1], snap_sel[1], snap_adr[1]} !== {3'b110, 4'hF, SRC})
      $display("FAIL norm_rd0 got %b/%h exp 110F/%h", {snap_busy[1], snap_stb[1], snap_we[1], snap_sel[1]}, snap_adr[1], SRC); else pass_n++;
    tot_n++; if ({snap_stb[3], snap_we[3], snap_adr[3], snap_dat[3]} !== 66'd0)
      $display("FAIL norm_rgap_idle got %b%b %h %h exp 0", snap_stb[3], snap_we[3], snap_adr[3], snap_dat[3]); else pass_n++;
    tot_n++; if ({snap_stb[4], snap_we[4], snap_adr[4], snap_dat[4]} !== {2'b11, DST, 32'h1})
      $display("FAIL norm_wr0 got %b%b %h %h exp 11 %h 1", snap_stb[4], snap_we[4], snap_adr[4], snap_dat[4], DST); else pass_n++;
    tot_n++; if (snap_adr[7] !== SRC + 32'd4) $display("FAIL norm_rd1_adr got %h exp %h", snap_adr[7], SRC + 32'd4); else pass_n++;
    tot_n++; if (busy_v[0] !== 1'b0) $display("FAIL norm_busy_in_done got %b exp 0", busy_v[0]); else pass_n++;
    tot_n++; if (cnt_v[0] !== 9'd33) $display("FAIL norm_count got %0d exp 33", cnt_v[0]); else pass_n++;
    tot_n++; if (err_v[0] !== 1'b0) $display("FAIL norm_err got %b exp 0", err_v[0]); else pass_n++;
    tot_n++; if ({rd_n_v[0], wr_n_v[0], wr_mask_v[0]} !== {8'd8, 8'd8, 8'hFF})
      $display("FAIL norm_accesses got rd=%0d wr=%0d mask=%h exp 8 8 ff", rd_n_v[0], wr_n_v[0], wr_mask_v[0]); else pass_n++;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (dst_v[0][i] !== src[i]) ok = 1'b0;
    tot_n++; if (!ok || bad_v[0] || dup_v[0]) $display("FAIL norm_dst_data got ok=%b bad=%b dup=%b exp 1 0 0", ok, bad_v[0], dup_v[0]); else pass_n++;
    @(negedge clk);
    tot_n++; if (done_v[0] !== 1'b0) $display("FAIL norm_done_pulse got %b exp 0", done_v[0]); else pass_n++;
  endtask

  task automatic test_skip_zero();
    int lat;
    load_src(32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    ack_mode = 1'b0; block_wr = -1;
    clear_log();
    run_xfer(1, 0, lat);
    tot_n++; if (lat !== 31) $display("FAIL skip_done_lat got %0d exp 31", lat); else pass_n++;
    tot_n++; if ({rd_n_v[1], wr_n_v[1], wr_mask_v[1]} !== {8'd8, 8'd2, 8'h03})
      $display("FAIL skip_accesses got rd=%0d wr=%0d mask=%h exp 8 2 03", rd_n_v[1], wr_n_v[1], wr_mask_v[1]); else pass_n++;
    tot_n++; if (cnt_v[1] !== 9'd33) $display("FAIL skip_count got %0d exp 33", cnt_v[1]); else pass_n++;
    tot_n++; if (dst_v[1][1] !== 32'hFFFF_FFFF) $display("FAIL skip_dst1 got %h exp ffffffff", dst_v[1][1]); else pass_n++;
  endtask

  task automatic test_lingering_ack();
    int lat;
    load_src(32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    ack_mode = 1'b1; block_wr = -1;
    clear_log();
    run_xfer(0, 0, lat);
    tot_n++; if (lat !== 48) $display("FAIL ling_done_lat got %0d exp 48", lat); else pass_n++;
    tot_n++; if ({rd_n_v[0], rd_mask_v[0], dup_v[0]} !== {8'd8, 8'hFF, 1'b0})
      $display("FAIL ling_reads got n=%0d mask=%h dup=%b exp 8 ff 0", rd_n_v[0], rd_mask_v[0], dup_v[0]); else pass_n++;
    tot_n++; if ({wr_n_v[0], wr_mask_v[0], bad_v[0]} !== {8'd8, 8'hFF, 1'b0})
      $display("FAIL ling_writes got n=%0d mask=%h bad=%b exp 8 ff 0", wr_n_v[0], wr_mask_v[0], bad_v[0]); else pass_n++;
    tot_n++; if (cnt_v[0] !== 9'd33) $display("FAIL ling_count got %0d exp 33", cnt_v[0]); else pass_n++;
    ack_mode = 1'b0;
  endtask

  task automatic test_timeout();
    int lat;
    // popcounts 1 + 2 + 4 + 2 = 9 over words 0..3
    load_src(32'h0000_0001, 32'h0000_0003, 32'h0000_00F0, 32'h8000_0001, 32'hFFFF_FFFF);
    ack_mode = 1'b0; block_wr = 3;
    clear_log();
    run_xfer(0, 0, lat);
    tot_n++; if (lat !== 38) $display("FAIL tmo_done_lat got %0d exp 38", lat); else pass_n++;
    tot_n++; if (err_v[0] !== 1'b1) $display("FAIL tmo_err got %b exp 1", err_v[0]); else pass_n++;
    tot_n++; if (max_run_v[0] !== 8'd16) $display("FAIL tmo_stb_len got %0d exp 16", max_run_v[0]); else pass_n++;
    tot_n++; if (cnt_v[0] !== 9'd9) $display("FAIL tmo_count got %0d exp 9", cnt_v[0]); else pass_n++;
    tot_n++; if ({stb_mask_v[0], rd_n_v[0], wr_n_v[0]} !== {8'h0F, 8'd4, 8'd3})
      $display("FAIL tmo_access got mask=%h rd=%0d wr=%0d exp 0f 4 3", stb_mask_v[0], rd_n_v[0], wr_n_v[0]); else pass_n++;
    repeat (3) @(negedge clk);
    tot_n++; if ({err_v[0], stb_v[0]} !== 2'b10) $display("FAIL tmo_sticky got err=%b stb=%b exp 1 0", err_v[0], stb_v[0]); else pass_n++;
    block_wr = -1;
  endtask

  task automatic test_start_handling();
    int lat;
    load_src(32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    clear_log();
    run_xfer(0, 10, lat);
    tot_n++; if ({snap_err1, snap_cnt1} !== 10'd0) $display("FAIL start_clear got err=%b cnt=%0d exp 0 0", snap_err1, snap_cnt1); else pass_n++;
    tot_n++; if (lat !== 48) $display("FAIL start_busy_lat got %0d exp 48", lat); else pass_n++;
    repeat (4) @(negedge clk);
    tot_n++; if ({busy_v[0], rd_n_v[0], cnt_v[0]} !== {1'b0, 8'd8, 9'd33})
      $display("FAIL start_ignored got busy=%b rd=%0d cnt=%0d exp 0 8 33", busy_v[0], rd_n_v[0], cnt_v[0]); else pass_n++;
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic found;
    load_src(32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    clear_log();
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (stb_v[0] && we_v[0] && adr_v[0] == DST + 32'd8) begin found = 1'b1; break; end
      @(negedge clk);
    end
    tot_n++; if (!found) $display("FAIL rmid_reach_wr2 got 0 exp 1"); else pass_n++;
    rst = 1'b1;
    #1;
    tot_n++; if ({cyc_v[0], stb_v[0], busy_v[0], done_v[0]} !== 4'b0000)
      $display("FAIL rmid_drop got %b exp 0000", {cyc_v[0], stb_v[0], busy_v[0], done_v[0]}); else pass_n++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    tot_n++; if ({done_v[0], busy_v[0]} !== 2'b00) $display("FAIL rmid_no_done got %b exp 00", {done_v[0], busy_v[0]}); else pass_n++;
    clear_log();
    run_xfer(0, 0, lat);
    tot_n++; if ({snap_stb[1], snap_adr[1]} !== {1'b1, SRC}) $display("FAIL rmid_restart got %b %h exp 1 %h", snap_stb[1], snap_adr[1], SRC); else pass_n++;
    tot_n++; if ({lat[7:0], cnt_v[0], wr_mask_v[0]} !== {8'd48, 9'd33, 8'hFF})
      $display("FAIL rmid_complete got lat=%0d cnt=%0d mask=%h exp 48 33 ff", lat, cnt_v[0], wr_mask_v[0]); else pass_n++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) src[i] = 32'h0;
    test_reset();
    test_normal();
    test_skip_zero();
    test_lingering_ack();
    test_timeout();
    test_start_handling();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule

// File: doc/spike_fwd_dma.md
# spike_fwd_dma

Wishbone master that moves one timestep of output spikes from core 0 to core 1. On `start_i` it reads `NUM_WORDS` words from the core-0 output-spike memory at `SRC_BASE`. It writes each word to the core-1 axon-input memory at `DST_BASE` and counts the total set bits it forwards. It sits on the same Wishbone bus as the spike memories, beside the CPU, behind the bus arbiter.

## Interface
- `SRC_BASE`, default 32'h80040000: byte address of word 0 of the source memory.
- `DST_BASE`, default 32'h80060000: byte address of word 0 of the destination memory.
- `NUM_WORDS`, default 8: number of 32-bit words per transfer (>= 1).
- `TIMEOUT`, default 16: maximum number of cycles STB is held high waiting for ACK.
- `SKIP_ZERO`, default 0: when 1, a read word equal to 0 is not written.
- `CNT_W`, default 9: width of `spike_count_o`; must be >= clog2(NUM_WORDS*32+1).
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  single-cycle transfer request.
- `busy_o`  out  1  transfer in progress.
- `done_o`  out  1  single-cycle pulse when a transfer ends (normal or aborted).
- `err_o`  out  1  sticky timeout flag; cleared when the next start is accepted.
- `spike_count_o`  out  CNT_W  popcount accumulated over all words read.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone master controls.
- `wbm_sel_o`  out  4  byte selects; always 4'hF during a transaction.
- `wbm_adr_o`, `wbm_dat_o`  out  32 each  address and write data.
- `wbm_ack_i`  in  1  acknowledge.
- `wbm_dat_i`  in  32  read data.

## Operation
- **States:** IDLE, RD, RGAP, WR, WGAP, DONE. Word index `idx` runs 0..NUM_WORDS-1.
- **IDLE:**
  - `start_i`=1 moves to RD.
  - In the same edge: idx=0, `spike_count_o`=0, `err_o`=0.
  - `start_i` is ignored in every other state.
- **RD:**
  - Drives cyc=stb=1, we=0, adr=SRC_BASE+4*idx.
  - On ack: capture `wbm_dat_i` into the word buffer.
  - On ack: `spike_count_o` += popcount(`wbm_dat_i`), modulo 2^CNT_W.
  - Then move to RGAP.
- **RGAP:** one cycle with cyc=stb=0.
  - If SKIP_ZERO=1 and buffer==0, skip the write: for the last index go to DONE; otherwise idx+1 and go to RD.
  - Otherwise go to WR.
- **WR:**
  - Drives cyc=stb=1, we=1, sel=4'hF, adr=DST_BASE+4*idx, dat=buffer.
  - On ack, move to WGAP.
- **WGAP:** one cycle with cyc=stb=0.
  - For the last index, go to DONE.
  - Otherwise set idx+1 and go to RD.
- **DONE:** one cycle. `done_o`=1, then return to IDLE.
- **Gap rule:** the gap states exist because responders keep ACK asserted while STB stays high. Any `wbm_ack_i` seen while stb=0 is ignored.
- **Timeout:**
  - A counter clears when RD or WR is entered and increments each cycle with no ack.
  - Ack absent on the TIMEOUT-th STB cycle means abort: `err_o`=1, and go to DONE.
  - STB is therefore high for at most TIMEOUT cycles.
  - `spike_count_o` keeps the words read so far. No further bus access occurs.
- **Bus idle:** `wbm_dat_o`, `wbm_adr_o` and `wbm_we_o` are 0 whenever stb=0.

## Timing
- **Reset values:** all outputs 0; state IDLE; idx 0; buffer 0; timeout counter 0.
- **Reset mid-transfer:** cyc and stb drop immediately (asynchronous). No done pulse is produced.
- **Per-word timing** (start sampled at edge k, responder with registered one-cycle ack):
  - Word 0 read STB in cycle k+1, ack in k+2.
  - RGAP in k+3.
  - Write STB in k+4, ack in k+5.
  - WGAP in k+6.
  - Next read STB in k+7, giving 6 cycles per word.
- **End of transfer** (NUM_WORDS=8, no skips, no stalls):
  - Last write ack in cycle k+47.
  - `done_o` in k+48.
  - A new start is accepted from k+49.
- **Skipped words:** each costs 3 cycles (RD, ack cycle, RGAP).
- **Stalls:** ack wait states extend RD or WR one cycle per stall cycle.
- **`busy_o`:** 1 in RD, RGAP, WR and WGAP; 0 in IDLE and DONE.
- **`spike_count_o`:** updates on the edge ending each read ack cycle and is stable otherwise.

## Test plan
- **Normal transfer:**
  - Stimulus: memory model with 1-cycle ack; source words 32'h0000_0001, 32'hFFFF_FFFF, then 6 words of 0; start.
  - Required: 8 reads then 8 writes at DST_BASE+0..+28 with identical data.
  - Required: spike_count_o=33; done_o at k+48; err_o=0.
- **SKIP_ZERO=1** with the same data:
  - Required: exactly 2 writes (words 0 and 1), spike_count_o=33.
  - Required: done_o at k+1+6*2+3*6 = k+31.
- **Lingering ACK:** responder holds ack high while stb is high.
  - Required: each word is read exactly once; acks during gap cycles are ignored.
  - Required: no extra index increment.
- **Timeout:**
  - Stimulus: responder never acks the write of word 3; TIMEOUT=16.
  - Required: STB high for exactly 16 cycles, then err_o=1 and a done_o pulse.
  - Required: spike_count_o holds the popcount of words 0-3; no access to word 4.
- **Start handling:**
  - Required: start_i pulsed during busy is ignored.
  - Required: start after an error clears err_o and resets spike_count_o to 0 at acceptance.
- **Reset mid-transfer:**
  - Stimulus: assert wb_rst_i during the WR of word 2.
  - Required: cyc, stb, busy and done go to 0 immediately; a start after reset begins again from word 0.
